// File: rtl/cape_pin_owner_ctrl.sv
// Cape pad ownership controller: APB-programmed MSS/fabric pad mux with
// break-before-make handover (tri-state dead time) on ownership changes.
module cape_pin_owner_ctrl #(
    parameter int unsigned NUM_PINS    = 28,
    parameter int unsigned DEAD_CYCLES = 4
) (
    input  logic                PCLK,
    input  logic                PRESETN,
    input  logic                psel,
    input  logic                penable,
    input  logic                pwrite,
    input  logic [7:0]          paddr,
    input  logic [31:0]         pwdata,
    output logic [31:0]         prdata,
    input  logic [NUM_PINS-1:0] MSS_OE,
    input  logic [NUM_PINS-1:0] MSS_OUT,
    input  logic [NUM_PINS-1:0] FAB_OE,
    input  logic [NUM_PINS-1:0] FAB_OUT,
    output logic [NUM_PINS-1:0] PAD_OE,
    output logic [NUM_PINS-1:0] PAD_OUT,
    input  logic [NUM_PINS-1:0] PAD_IN,
    output logic [NUM_PINS-1:0] MSS_IN,
    output logic [NUM_PINS-1:0] FAB_IN,
    output logic                busy,
    output logic                irq
);

    typedef enum logic [1:0] {IDLE, DRAIN, COMMIT} state_t;

    localparam logic [7:0] A_REQ    = 8'h00;
    localparam logic [7:0] A_ACT    = 8'h04;
    localparam logic [7:0] A_FTRI   = 8'h08;
    localparam logic [7:0] A_STATUS = 8'h0C;
    localparam logic [7:0] CNT_LOAD = 8'(DEAD_CYCLES - 1);

    state_t              state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [NUM_PINS-1:0] owner_req_q, owner_req_d;
    logic [NUM_PINS-1:0] owner_act_q, owner_act_d;
    logic [NUM_PINS-1:0] force_tri_q, force_tri_d;
    logic [NUM_PINS-1:0] chg_q, chg_d;
    logic [NUM_PINS-1:0] pend_q, pend_d;
    logic [31:0]         prdata_q, prdata_d;
    logic [31:0]         rdata;
    logic [NUM_PINS-1:0] tri_v;
    logic                wr_en, rd_setup;
    logic                unused_pwdata;

    assign wr_en         = psel & penable & pwrite;
    assign rd_setup      = psel & ~penable & ~pwrite;
    assign unused_pwdata = ^pwdata;

    assign busy = (state_q != IDLE);
    assign irq  = (state_q == COMMIT);

    always_comb begin
        rdata = '0;
        case (paddr)
            A_REQ:    rdata = 32'(owner_req_q);
            A_ACT:    rdata = 32'(owner_act_q);
            A_FTRI:   rdata = 32'(force_tri_q);
            A_STATUS: rdata = {16'h0000, cnt_q, 7'h00, busy};
            default:  rdata = '0;
        endcase
    end

    always_comb begin
        owner_req_d = owner_req_q;
        force_tri_d = force_tri_q;
        prdata_d    = prdata_q;
        if (wr_en && paddr == A_REQ)  owner_req_d = pwdata[NUM_PINS-1:0];
        if (wr_en && paddr == A_FTRI) force_tri_d = pwdata[NUM_PINS-1:0];
        if (rd_setup)                 prdata_d    = rdata;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        chg_d       = chg_q;
        pend_d      = pend_q;
        owner_act_d = owner_act_q;
        case (state_q)
            IDLE: begin
                if (owner_req_q != owner_act_q) begin
                    chg_d   = owner_req_q ^ owner_act_q;
                    pend_d  = owner_req_q;
                    cnt_d   = CNT_LOAD;
                    state_d = DRAIN;
                end else begin
                    chg_d = '0;
                end
            end
            DRAIN: begin
                if (cnt_q == 8'd0) state_d = COMMIT;
                else               cnt_d   = cnt_q - 8'd1;
            end
            COMMIT: begin
                owner_act_d = pend_q;
                chg_d       = '0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            owner_req_q <= '0;
            owner_act_q <= '0;
            force_tri_q <= '0;
            chg_q       <= '0;
            pend_q      <= '0;
            prdata_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            owner_req_q <= owner_req_d;
            owner_act_q <= owner_act_d;
            force_tri_q <= force_tri_d;
            chg_q       <= chg_d;
            pend_q      <= pend_d;
            prdata_q    <= prdata_d;
        end
    end

    // chg is only meaningful outside IDLE, so gate it with busy
    assign tri_v   = force_tri_q | (busy ? chg_q : '0);
    assign PAD_OE  = ~tri_v & ((owner_act_q & FAB_OE)  | (~owner_act_q & MSS_OE));
    assign PAD_OUT = ~tri_v & ((owner_act_q & FAB_OUT) | (~owner_act_q & MSS_OUT));
    assign MSS_IN  = PAD_IN;
    assign FAB_IN  = PAD_IN;
    assign prdata  = prdata_q;

endmodule

// File: tb/tb_cape_pin_owner_ctrl.sv
// Bench for cape_pin_owner_ctrl: directed test-plan scenarios with literal
// expectations plus randomized APB/pin traffic against a handover-age model.
module tb_cape_pin_owner_ctrl;

    localparam int NP = 28;
    localparam int D  = 4;

    logic          PCLK = 1'b0;
    logic          PRESETN = 1'b0;
    logic          psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [7:0]    paddr = '0;
    logic [31:0]   pwdata = '0;
    logic [31:0]   prdata;
    logic [NP-1:0] MSS_OE = '0, MSS_OUT = '0, FAB_OE = '0, FAB_OUT = '0, PAD_IN = '0;
    logic [NP-1:0] PAD_OE, PAD_OUT, MSS_IN, FAB_IN;
    logic          busy, irq;

    int checks = 0;
    int errors = 0;
    int irq_seen = 0;

    cape_pin_owner_ctrl #(.NUM_PINS(NP), .DEAD_CYCLES(D)) dut (
        .PCLK(PCLK), .PRESETN(PRESETN), .psel(psel), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
        .MSS_OE(MSS_OE), .MSS_OUT(MSS_OUT), .FAB_OE(FAB_OE), .FAB_OUT(FAB_OUT),
        .PAD_OE(PAD_OE), .PAD_OUT(PAD_OUT), .PAD_IN(PAD_IN),
        .MSS_IN(MSS_IN), .FAB_IN(FAB_IN), .busy(busy), .irq(irq)
    );

    always #5 PCLK = ~PCLK;

    // Model: m_age counts cycles since a handover left IDLE (0 = no handover,
    // 1..D = dead-time cycles, D+1 = commit cycle).
    logic [NP-1:0] m_req, m_act, m_ftri, m_chg, m_pend;
    logic [31:0]   m_prdata;
    int            m_age;

    function automatic logic [31:0] model_read(input logic [7:0] a);
        int cnt;
        cnt = (m_age >= 1 && m_age <= D) ? (D - m_age) : 0;
        case (a)
            8'h00:   return 32'(m_req);
            8'h04:   return 32'(m_act);
            8'h08:   return 32'(m_ftri);
            8'h0C:   return (32'(cnt) << 8) | ((m_age != 0) ? 32'd1 : 32'd0);
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            m_req <= '0; m_act <= '0; m_ftri <= '0; m_chg <= '0; m_pend <= '0;
            m_prdata <= '0; m_age <= 0;
        end else begin
            if (psel && penable && pwrite && paddr == 8'h00) m_req  <= pwdata[NP-1:0];
            if (psel && penable && pwrite && paddr == 8'h08) m_ftri <= pwdata[NP-1:0];
            if (psel && !penable && !pwrite) m_prdata <= model_read(paddr);
            if (m_age == 0) begin
                if (m_req != m_act) begin
                    m_age  <= 1;
                    m_chg  <= m_req ^ m_act;
                    m_pend <= m_req;
                end
            end else if (m_age <= D) begin
                m_age <= m_age + 1;
            end else begin
                m_act <= m_pend;
                m_age <= 0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare of all outputs against the model
    always @(negedge PCLK) begin
        logic [NP-1:0] t, e_oe, e_out;
        t     = m_ftri | ((m_age != 0) ? m_chg : '0);
        e_oe  = ~t & ((m_act & FAB_OE)  | (~m_act & MSS_OE));
        e_out = ~t & ((m_act & FAB_OUT) | (~m_act & MSS_OUT));
        chk("PAD_OE",  32'(PAD_OE),  32'(e_oe));
        chk("PAD_OUT", 32'(PAD_OUT), 32'(e_out));
        chk("MSS_IN",  32'(MSS_IN),  32'(PAD_IN));
        chk("FAB_IN",  32'(FAB_IN),  32'(PAD_IN));
        chk("busy",    32'(busy),    (m_age != 0) ? 32'd1 : 32'd0);
        chk("irq",     32'(irq),     (m_age == D + 1) ? 32'd1 : 32'd0);
        chk("prdata",  prdata,       m_prdata);
        if (irq) irq_seen++;
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge PCLK);
            #1;
        end
    endtask

    task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
        tick();
        penable = 1'b1;
        tick();
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [7:0] a, output logic [31:0] d);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        tick();
        penable = 1'b1;
        d = prdata;
        tick();
        psel = 1'b0; penable = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        int base, lowcnt;

        PRESETN = 1'b0;
        MSS_OE = 28'h0FFFFFFF; MSS_OUT = 28'h5;
        FAB_OE = 28'h20; FAB_OUT = 28'h20; PAD_IN = 28'h0ABCDEF;
        tick(3);
        PRESETN = 1'b1;
        tick(2);
        chk("rst_pad_oe",  32'(PAD_OE),  32'h0FFFFFFF);
        chk("rst_pad_out", 32'(PAD_OUT), 32'h5);
        chk("rst_prdata",  prdata,       32'h0);
        chk("rst_busy",    32'(busy),    32'h0);

        // single handover of bit 5
        base = irq_seen;
        apb_write(8'h00, 32'h20);
        lowcnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge PCLK);
            if (!PAD_OE[5]) lowcnt++;
        end
        #1;
        chk("ho_tri_cycles", 32'(lowcnt), 32'd5);
        chk("ho_irq_pulses", 32'(irq_seen - base), 32'd1);
        chk("ho_pad_out5",   32'(PAD_OUT[5]), 32'd1);
        apb_read(8'h04, rd);
        chk("ho_owner_act", rd, 32'h20);

        // return to MSS, then overlapping requests
        apb_write(8'h00, 32'h0);
        tick(10);
        base = irq_seen;
        apb_write(8'h00, 32'h20);
        apb_write(8'h00, 32'h60);
        tick(5);
        apb_read(8'h04, rd);
        chk("ovl_first_act", rd, 32'h20);
        tick(10);
        apb_read(8'h04, rd);
        chk("ovl_final_act", rd, 32'h60);
        chk("ovl_irq_pulses", 32'(irq_seen - base), 32'd2);

        // STATUS counter sampled across two handovers
        apb_write(8'h00, 32'h61);
        tick();
        apb_read(8'h0C, rd); chk("status_cnt3", rd, 32'h301);
        apb_read(8'h0C, rd); chk("status_cnt1", rd, 32'h101);
        tick(10);
        apb_write(8'h00, 32'h60);
        tick(2);
        apb_read(8'h0C, rd); chk("status_cnt2", rd, 32'h201);
        apb_read(8'h0C, rd); chk("status_cnt0", rd, 32'h001);
        tick(10);
        apb_read(8'h10, rd); chk("unmapped_read", rd, 32'h0);

        // FORCE_TRI
        apb_write(8'h08, 32'h3);
        chk("ftri_on",  32'(PAD_OE[1:0]), 32'h0);
        apb_write(8'h08, 32'h0);
        chk("ftri_off", 32'(PAD_OE[1:0]), 32'h3);
        apb_read(8'h04, rd); chk("ftri_act_kept", rd, 32'h60);

        // reset in the middle of the dead time
        base = irq_seen;
        apb_write(8'h00, 32'h0);
        tick(2);
        PRESETN = 1'b0;
        #1;
        chk("midrst_pad_oe",  32'(PAD_OE),  32'h0FFFFFFF);
        chk("midrst_pad_out", 32'(PAD_OUT), 32'h5);
        chk("midrst_busy",    32'(busy),    32'h0);
        tick(2);
        PRESETN = 1'b1;
        tick();
        apb_read(8'h00, rd); chk("midrst_req", rd, 32'h0);
        apb_read(8'h04, rd); chk("midrst_act", rd, 32'h0);
        chk("midrst_irq", 32'(irq_seen - base), 32'd0);

        apb_write(8'h00, 32'hFFFFFFFF);
        apb_read(8'h00, rd); chk("req_mask", rd, 32'h0FFFFFFF);
        tick(10);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            logic [7:0] a;
            logic [31:0] d;
            MSS_OE  = NP'($urandom); MSS_OUT = NP'($urandom);
            FAB_OE  = NP'($urandom); FAB_OUT = NP'($urandom);
            PAD_IN  = NP'($urandom);
            a = 8'($urandom_range(0, 4) * 4);
            case ($urandom_range(0, 3))
                0:       d = $urandom;
                1:       d = 32'(1) << $urandom_range(0, 31);
                2:       d = $urandom & 32'h000000FF;
                default: d = 32'h0;
            endcase
            case ($urandom_range(0, 3))
                0:       apb_write(a, d);
                1:       apb_read(a, d);
                2:       apb_write(8'h00, d);
                default: tick($urandom_range(1, 6));
            endcase
        end
        tick(12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
